// File: rtl/bus_xbar_if.sv
// Bus bundle between the requesting masters, the bus_xbar interconnect and the on-chip slaves.
// The xbar modport is the interconnect's own view; master and slave are the two client views.
interface bus_xbar_if #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 4,
  parameter int AW        = 32,
  parameter int DW        = 32
);
  logic [N_MASTERS-1:0]    m_req_i;
  logic [N_MASTERS*AW-1:0] m_addr_i;
  logic [N_MASTERS*DW-1:0] m_wdata_i;
  logic [N_MASTERS-1:0]    m_we_i;
  logic [N_MASTERS*2-1:0]  m_hb_i;
  logic [N_MASTERS-1:0]    m_gnt_o;
  logic                    m_err_o;
  logic [DW-1:0]           m_rdata_o;

  logic [N_SLAVES-1:0]     s_cs_o;
  logic                    s_req_o;
  logic [AW-1:0]           s_addr_o;
  logic [DW-1:0]           s_wdata_o;
  logic                    s_we_o;
  logic [1:0]              s_hb_o;
  logic [N_SLAVES-1:0]     s_gnt_i;
  logic [N_SLAVES*DW-1:0]  s_rdata_i;

  modport master (
    output m_req_i, m_addr_i, m_wdata_i, m_we_i, m_hb_i,
    input  m_gnt_o, m_err_o, m_rdata_o
  );

  modport slave (
    input  s_cs_o, s_req_o, s_addr_o, s_wdata_o, s_we_o, s_hb_o,
    output s_gnt_i, s_rdata_i
  );

  modport xbar (
    input  m_req_i, m_addr_i, m_wdata_i, m_we_i, m_hb_i, s_gnt_i, s_rdata_i,
    output m_gnt_o, m_err_o, m_rdata_o,
           s_cs_o, s_req_o, s_addr_o, s_wdata_o, s_we_o, s_hb_o
  );
endinterface

// File: rtl/bus_xbar.sv
// N-master round-robin bus interconnect with windowed one-hot slave decode, registered
// responses and an error termination for decode misses and slaves that never grant.
module bus_xbar #(
  parameter int                      N_MASTERS = 2,
  parameter int                      N_SLAVES  = 4,
  parameter int                      AW        = 32,
  parameter int                      DW        = 32,
  parameter logic [N_SLAVES*AW-1:0]  SLV_BASE  = {AW'(32'h3000), AW'(32'h2000),
                                                  AW'(32'h1000), AW'(32'h0000)},
  parameter logic [N_SLAVES*AW-1:0]  SLV_MASK  = {N_SLAVES{AW'(32'hFFFF_F000)}},
  parameter int                      TIMEOUT   = 15
) (
  input  logic     clk_i,
  input  logic     rst_i,
  bus_xbar_if.xbar bus
);
  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t                state;
  logic [MW-1:0]         last_winner;
  logic [MW-1:0]         winner;
  logic [CW-1:0]         cnt;
  logic [N_SLAVES-1:0]   cs_q;
  logic                  req_q;
  logic [AW-1:0]         addr_q;
  logic [DW-1:0]         wdata_q;
  logic                  we_q;
  logic [1:0]            hb_q;
  logic [N_MASTERS-1:0]  gnt_q;
  logic                  err_q;
  logic [DW-1:0]         rdata_q;

  logic                  arb_valid;
  logic [MW-1:0]         arb_idx;
  logic [MW-1:0]         arb_cand;
  logic [AW-1:0]         win_addr;
  logic [DW-1:0]         win_wdata;
  logic                  win_we;
  logic [1:0]            win_hb;
  logic                  dec_hit;
  logic [N_SLAVES-1:0]   dec_sel;
  logic                  sel_gnt;
  logic [DW-1:0]         sel_rdata;

  // Round-robin: walk backwards from the lowest-priority candidate so the last hit is the winner.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    arb_valid = 1'b0;
    arb_idx   = last_winner;
    arb_cand  = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      arb_cand = MW'((int'(last_winner) + 1 + k) % N_MASTERS);
      if (bus.m_req_i[arb_cand]) begin
        arb_valid = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    win_hb    = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      if (arb_idx == MW'(m)) begin
        win_addr  = bus.m_addr_i[m*AW +: AW];
        win_wdata = bus.m_wdata_i[m*DW +: DW];
        win_we    = bus.m_we_i[m];
        win_hb    = bus.m_hb_i[m*2 +: 2];
      end
    end
  end

  // Lowest-numbered matching window wins, so scan downwards and let later hits overwrite.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((win_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_sel = N_SLAVES'(1) << i;
      end
    end
  end

  always_comb begin
    sel_gnt   = |(bus.s_gnt_i & cs_q);
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (cs_q[i]) sel_rdata = bus.s_rdata_i[i*DW +: DW];
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registers take non-blocking assignments; the synchronous reset clears every one of them.
    if (rst_i) begin
      state       <= ST_IDLE;
      last_winner <= MW'(N_MASTERS - 1);
      winner      <= '0;
      cnt         <= '0;
      cs_q        <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      hb_q        <= '0;
      gnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            winner  <= arb_idx;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            we_q    <= win_we;
            hb_q    <= win_hb;
            cnt     <= '0;
            if (dec_hit) begin
              cs_q  <= dec_sel;
              req_q <= 1'b1;
              state <= ST_BUSY;
            end else begin
              gnt_q   <= N_MASTERS'(1) << arb_idx;
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          // A grant in the last allowed cycle still beats the timeout.
          if (sel_gnt || cnt == CW'(TIMEOUT - 1)) begin
            gnt_q   <= N_MASTERS'(1) << winner;
            err_q   <= ~sel_gnt;
            rdata_q <= (sel_gnt && !we_q) ? sel_rdata : '0;
            req_q   <= 1'b0;
            cs_q    <= '0;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          gnt_q       <= '0;
          err_q       <= 1'b0;
          rdata_q     <= '0;
          last_winner <= winner;
          cnt         <= '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_gnt_o   = gnt_q;
  assign bus.m_err_o   = err_q;
  assign bus.m_rdata_o = rdata_q;
  assign bus.s_cs_o    = cs_q;
  assign bus.s_req_o   = req_q;
  assign bus.s_addr_o  = addr_q;
  assign bus.s_wdata_o = wdata_q;
  assign bus.s_we_o    = we_q;
  assign bus.s_hb_o    = hb_q;
endmodule

// File: tb/tb_bus_xbar.sv
// Self-checking bench for bus_xbar: a transaction-level model schedules the expected output
// timeline per accepted request, and directed scenarios pin that model with literal values.
module tb_bus_xbar;
  localparam int NM   = 2;
  localparam int NS   = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 15;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_xbar_if #(.N_MASTERS(NM), .N_SLAVES(NS), .AW(AW), .DW(DW)) bus ();

  bus_xbar #(.N_MASTERS(NM), .N_SLAVES(NS), .AW(AW), .DW(DW), .TIMEOUT(TO)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Address map and slave behaviour. Latency: 0 never grants, -1 grants constantly, k>=1 grants in selected cycle k.
  logic [AW-1:0] win_base [NS] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
  logic [AW-1:0] win_mask [NS] = '{default: 32'hFFFF_F000};
  logic [DW-1:0] slv_data [NS] = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
  int            slv_lat  [NS] = '{1, 1, 1, 1};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int armed_from = MAXC;
  int mdl_last   = NM - 1;
  int mdl_free_at = 0;

  bit [NM-1:0] exp_gnt   [MAXC];
  bit          exp_err   [MAXC];
  bit [DW-1:0] exp_rdata [MAXC];
  bit          exp_sreq  [MAXC];
  bit [NS-1:0] exp_cs    [MAXC];
  bit [AW-1:0] exp_addr  [MAXC];
  bit [DW-1:0] exp_wdata [MAXC];
  bit          exp_we    [MAXC];
  bit [1:0]    exp_hb    [MAXC];

  logic [NM-1:0] obs_gnt   [MAXC];
  logic          obs_err   [MAXC];
  logic [DW-1:0] obs_rdata [MAXC];
  logic          obs_sreq  [MAXC];
  logic [NS-1:0] obs_cs    [MAXC];
  logic          obs_we    [MAXC];
  logic [DW-1:0] obs_wdata [MAXC];
  logic [1:0]    obs_hb    [MAXC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_slot(input int k);
    exp_gnt[k] = '0;  exp_err[k] = 1'b0; exp_rdata[k] = '0; exp_sreq[k] = 1'b0;
    exp_cs[k]  = '0;  exp_addr[k] = '0;  exp_wdata[k] = '0; exp_we[k]   = 1'b0;
    exp_hb[k]  = '0;
  endtask

  // Once free, take the requests present this cycle and lay out the whole expected transaction.
  task automatic model_step(input int c);
    int            w;
    int            hit;
    int            lat;
    int            n;
    bit            err;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          we;
    logic [1:0]    hb;
    if (rst) begin
      for (int k = c + 1; k < c + TO + 4 && k < MAXC; k++) clear_slot(k);
      mdl_last    = NM - 1;
      mdl_free_at = c + 1;
      if (armed_from > c + 1) armed_from = c + 1;
      return;
    end
    if (c < mdl_free_at || bus.m_req_i == '0) return;
    w = -1;
    for (int k = 1; k <= NM; k++) begin
      int cand;
      cand = (mdl_last + k) % NM;
      if (w < 0 && ((bus.m_req_i >> cand) & NM'(1)) != '0) w = cand;
    end
    a   = bus.m_addr_i[w*AW +: AW];
    wd  = bus.m_wdata_i[w*DW +: DW];
    we  = ((bus.m_we_i >> w) & NM'(1)) != '0;
    hb  = bus.m_hb_i[w*2 +: 2];
    hit = -1;
    for (int i = 0; i < NS; i++)
      if (hit < 0 && (a & win_mask[i]) == win_base[i]) hit = i;
    mdl_last = w;
    if (hit < 0) begin
      n   = 0;
      err = 1'b1;
    end else begin
      lat = (slv_lat[hit] < 0) ? 1 : slv_lat[hit];
      if (lat >= 1 && lat <= TO) begin
        n   = lat;
        err = 1'b0;
      end else begin
        n   = TO;
        err = 1'b1;
      end
    end
    if (c + n + 1 >= MAXC) return;
    for (int j = 1; j <= n; j++) begin
      exp_sreq[c+j]  = 1'b1;
      exp_cs[c+j]    = NS'(1) << hit;
      exp_addr[c+j]  = a;
      exp_wdata[c+j] = wd;
      exp_we[c+j]    = we;
      exp_hb[c+j]    = hb;
    end
    exp_gnt[c+n+1]   = NM'(1) << w;
    exp_err[c+n+1]   = err;
    exp_rdata[c+n+1] = (err || we) ? '0 : slv_data[hit];
    mdl_free_at      = c + n + 2;
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      obs_gnt[cyc]   = bus.m_gnt_o;
      obs_err[cyc]   = bus.m_err_o;
      obs_rdata[cyc] = bus.m_rdata_o;
      obs_sreq[cyc]  = bus.s_req_o;
      obs_cs[cyc]    = bus.s_cs_o;
      obs_we[cyc]    = bus.s_we_o;
      obs_wdata[cyc] = bus.s_wdata_o;
      obs_hb[cyc]    = bus.s_hb_o;
      if (cyc >= armed_from) begin
        check($sformatf("m_gnt_o@%0d", cyc), bus.m_gnt_o, exp_gnt[cyc]);
        check($sformatf("m_err_o@%0d", cyc), bus.m_err_o, exp_err[cyc]);
        check($sformatf("s_req_o@%0d", cyc), bus.s_req_o, exp_sreq[cyc]);
        check($sformatf("s_cs_o@%0d",  cyc), bus.s_cs_o,  exp_cs[cyc]);
        if (exp_gnt[cyc] != '0)
          check($sformatf("m_rdata_o@%0d", cyc), bus.m_rdata_o, exp_rdata[cyc]);
        if (exp_sreq[cyc]) begin
          check($sformatf("s_addr_o@%0d",  cyc), bus.s_addr_o,  exp_addr[cyc]);
          check($sformatf("s_wdata_o@%0d", cyc), bus.s_wdata_o, exp_wdata[cyc]);
          check($sformatf("s_we_o@%0d",    cyc), bus.s_we_o,    exp_we[cyc]);
          check($sformatf("s_hb_o@%0d",    cyc), bus.s_hb_o,    exp_hb[cyc]);
        end
      end
      model_step(cyc);
    end
  end

  // Slave responder: counts the cycles it has been selected and grants according to its latency.
  initial begin
    int            sel_cnt [NS];
    logic [NS-1:0] gnt_bits;
    gnt_bits = '0;
    for (int j = 0; j < NS; j++) begin
      sel_cnt[j] = 0;
      bus.s_rdata_i[j*DW +: DW] = slv_data[j];
    end
    bus.s_gnt_i = '0;
    forever begin
      @(negedge clk);
      for (int j = 0; j < NS; j++) begin
        if (slv_lat[j] < 0) begin
          gnt_bits[j] = 1'b1;
        end else if (bus.s_req_o === 1'b1 && bus.s_cs_o[j] === 1'b1) begin
          sel_cnt[j]++;
          gnt_bits[j] = (slv_lat[j] != 0 && sel_cnt[j] == slv_lat[j]);
        end else begin
          sel_cnt[j]  = 0;
          gnt_bits[j] = 1'b0;
        end
      end
      bus.s_gnt_i = gnt_bits;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int m, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic we, input logic [1:0] hb);
    bus.m_addr_i[m*AW +: AW]  = a;
    bus.m_wdata_i[m*DW +: DW] = wd;
    bus.m_we_i[m]             = we;
    bus.m_hb_i[m*2 +: 2]      = hb;
    bus.m_req_i[m]            = 1'b1;
  endtask

  task automatic wait_gnt(input int m, output int gc);
    gc = -1;
    for (int k = 0; k < 40 && gc < 0; k++) begin
      step();
      if (obs_gnt[cyc-1][m] === 1'b1) gc = cyc - 1;
    end
    check($sformatf("grant to master %0d arrives", m), (gc >= 0) ? 1 : 0, 1);
  endtask

  initial begin
    int t0;
    int gc;
    int cnt;
    bus.m_req_i   = '0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;
    bus.m_we_i    = '0;
    bus.m_hb_i    = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset m_gnt_o", bus.m_gnt_o, 0);
    check("reset s_req_o", bus.s_req_o, 0);

    // Single read to slave 1.
    drive(0, 32'h1004, 32'h0, 1'b0, 2'd0);
    t0 = cyc;
    wait_gnt(0, gc);
    bus.m_req_i[0] = 1'b0;
    check("read grant latency", gc - t0, 2);
    check("read s_cs_o", obs_cs[t0+1], 4'b0010);
    check("read m_gnt_o", obs_gnt[t0+2], 2'b01);
    check("read m_rdata_o", obs_rdata[t0+2], 32'hDEAD_BEEF);
    check("read m_err_o", obs_err[t0+2], 0);

    // Round-robin from reset with both masters requesting continuously.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    drive(0, 32'h0010, 32'h0, 1'b0, 2'd0);
    drive(1, 32'h2020, 32'h0, 1'b0, 2'd1);
    t0 = cyc;
    repeat (12) step();
    bus.m_req_i = '0;
    check("rr grant 1", obs_gnt[t0+2], 2'b01);
    check("rr grant 2", obs_gnt[t0+5], 2'b10);
    check("rr grant 3", obs_gnt[t0+8], 2'b01);
    check("rr grant 4", obs_gnt[t0+11], 2'b10);
    check("rr rdata m1", obs_rdata[t0+5], 32'h2222_2222);
    check("rr idle gap", obs_gnt[t0+3], 2'b00);

    // Decode miss.
    step();
    drive(0, 32'h9000, 32'h0, 1'b0, 2'd0);
    t0 = cyc;
    wait_gnt(0, gc);
    bus.m_req_i[0] = 1'b0;
    check("miss grant latency", gc - t0, 1);
    check("miss m_err_o", obs_err[t0+1], 1);
    check("miss m_rdata_o", obs_rdata[t0+1], 0);
    check("miss s_req_o", obs_sreq[t0+1], 0);

    // Timeout: slave 2 never grants, the others grant constantly and must be ignored.
    slv_lat = '{-1, -1, 0, -1};
    step();
    drive(0, 32'h2000, 32'h0, 1'b0, 2'd0);
    t0 = cyc;
    wait_gnt(0, gc);
    bus.m_req_i[0] = 1'b0;
    cnt = 0;
    for (int k = t0; k <= t0 + 17; k++) if (obs_sreq[k] === 1'b1) cnt++;
    check("timeout s_req_o cycles", cnt, 15);
    check("timeout grant latency", gc - t0, 16);
    check("timeout m_err_o", obs_err[t0+16], 1);
    check("timeout m_rdata_o", obs_rdata[t0+16], 0);

    // Grant on the final BUSY cycle beats the timeout.
    slv_lat = '{-1, -1, 15, -1};
    step();
    drive(0, 32'h2000, 32'h0, 1'b0, 2'd0);
    t0 = cyc;
    wait_gnt(0, gc);
    bus.m_req_i[0] = 1'b0;
    check("late grant latency", gc - t0, 16);
    check("late grant m_err_o", obs_err[t0+16], 0);
    check("late grant m_rdata_o", obs_rdata[t0+16], 32'h2222_2222);

    // Write pass-through; master 1 drops its request while BUSY.
    slv_lat = '{-1, -1, -1, 3};
    step();
    drive(1, 32'h3000, 32'h0000_00A5, 1'b1, 2'd2);
    t0 = cyc;
    step();
    bus.m_req_i[1] = 1'b0;
    wait_gnt(1, gc);
    check("write s_we_o", obs_we[t0+1], 1);
    check("write s_wdata_o", obs_wdata[t0+1], 32'h0000_00A5);
    check("write s_hb_o", obs_hb[t0+1], 2);
    check("write s_cs_o", obs_cs[t0+1], 4'b1000);
    check("write grant latency", gc - t0, 4);
    check("write m_gnt_o", obs_gnt[gc], 2'b10);
    check("write m_rdata_o", obs_rdata[gc], 0);

    // Reset for two cycles in the middle of BUSY abandons the transaction.
    slv_lat = '{-1, -1, 0, -1};
    step();
    drive(0, 32'h2000, 32'h0, 1'b0, 2'd0);
    t0 = cyc;
    repeat (3) step();
    rst = 1'b1;
    bus.m_req_i = '0;
    repeat (2) step();
    rst = 1'b0;
    check("post-reset s_addr_o", bus.s_addr_o, 0);
    check("post-reset m_rdata_o", bus.m_rdata_o, 0);
    repeat (20) step();
    cnt = 0;
    for (int k = t0; k <= t0 + 24; k++) if (obs_gnt[k] !== 2'b00) cnt++;
    check("reset abandons grant", cnt, 0);
    check("s_req_o before reset", obs_sreq[t0+3], 1);
    check("s_req_o after reset", obs_sreq[t0+4], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
